// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: state encoding,
// default widths and the tag that marks the PSR flags beat.
package rf_dump_reader_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NREGS_DEF  = 16;
  localparam int STATE_W    = 3;

  // Tag carried by the flags beat: one past the last register index.
  localparam logic [ADDR_W_DEF:0] FLAGS_TAG = (ADDR_W_DEF+1)'(NREGS_DEF);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SEND   = 3'd2,
    ST_FLAGS  = 3'd3,
    ST_SEND_F = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/rf_dump_outreg.sv
// Output holding register for the dump stream. A loaded beat stays frozen
// until it is cleared (handshake or abort); loads are refused while a beat
// is still pending, so data/tag cannot change under a stalled consumer.
module rf_dump_outreg
  import rf_dump_reader_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [WIDTH-1:0]  dIn,
  input  logic [ADDR_W:0]   tagIn,
  output logic [WIDTH-1:0]  outData,
  output logic [ADDR_W:0]   outTag,
  output logic              outValid
);

  logic [WIDTH-1:0] dataR;
  logic [ADDR_W:0]  tagR;
  logic             validR;

  // Beat storage: clear drops valid, load captures only into an empty slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataR  <= '0;
      tagR   <= '0;
      validR <= 1'b0;
    end else if (clear) begin
      validR <= 1'b0;
    end else if (load && !validR) begin
      dataR  <= dIn;
      tagR   <= tagIn;
      validR <= 1'b1;
    end
  end

  assign outData  = dataR;
  assign outTag   = tagR;
  assign outValid = validR;

endmodule

// File: rtl/rf_dump_reader.sv
// Sequential register-file dump engine: walks addresses 0..NREGS-1 through
// a combinational read port and streams each word over valid/ready.
// Optional feature macro: RF_DUMP_FLAGS_EN appends a PSR flags beat.
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rfAddr,
  input  logic [WIDTH-1:0]  rfData,
`ifdef RF_DUMP_FLAGS_EN
  input  logic [WIDTH-1:0]  flags,
`endif
  output logic [WIDTH-1:0]  outData,
  output logic [ADDR_W:0]   outTag,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            stateR, nextStateS;
  logic [ADDR_W-1:0] idxR, idxNextS;
  logic [ADDR_W-1:0] rfAddrR, addrNextS;
  logic              busyR, doneR;
  logic              loadS, clearS, handshakeS;
  logic [WIDTH-1:0]  loadDataS;
  logic [ADDR_W:0]   loadTagS;

  assign handshakeS = outValid & outReady;

  // Next-state, index and output-register control; abort overrides all.
  always_comb begin
    nextStateS = stateR;
    idxNextS   = idxR;
    addrNextS  = rfAddrR;
    loadS      = 1'b0;
    clearS     = 1'b0;
    loadDataS  = '0;
    loadTagS   = '0;
    if (abort && (stateR != ST_IDLE)) begin
      nextStateS = ST_IDLE;
      idxNextS   = '0;
      clearS     = 1'b1;
    end else begin
      case (stateR)
        ST_IDLE: begin
          if (start) begin
            nextStateS = ST_FETCH;
            idxNextS   = '0;
            addrNextS  = '0;
          end else begin
            nextStateS = ST_IDLE;
          end
        end
        ST_FETCH: begin
          loadS      = 1'b1;
          loadDataS  = rfData;
          loadTagS   = {1'b0, idxR};
          nextStateS = ST_SEND;
        end
        ST_SEND: begin
          if (handshakeS) begin
            clearS = 1'b1;
            if (idxR < LAST_IDX) begin
              // Address is advanced here so it is already valid in FETCH.
              idxNextS   = idxR + ADDR_W'(1);
              addrNextS  = idxR + ADDR_W'(1);
              nextStateS = ST_FETCH;
            end else begin
`ifdef RF_DUMP_FLAGS_EN
              nextStateS = ST_FLAGS;
`else
              nextStateS = ST_DONE;
`endif
            end
          end else begin
            nextStateS = ST_SEND;
          end
        end
`ifdef RF_DUMP_FLAGS_EN
        ST_FLAGS: begin
          loadS      = 1'b1;
          loadDataS  = flags;
          loadTagS   = (ADDR_W+1)'(NREGS);
          nextStateS = ST_SEND_F;
        end
        ST_SEND_F: begin
          if (handshakeS) begin
            clearS     = 1'b1;
            nextStateS = ST_DONE;
          end else begin
            nextStateS = ST_SEND_F;
          end
        end
`endif
        ST_DONE: begin
          nextStateS = ST_IDLE;
          idxNextS   = '0;
        end
        default: begin
          nextStateS = ST_IDLE;
          idxNextS   = '0;
          clearS     = 1'b1;
        end
      endcase
    end
  end

  // State, index, read address and status flags; busy/done follow the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR  <= ST_IDLE;
      idxR    <= '0;
      rfAddrR <= '0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
    end else begin
      stateR  <= nextStateS;
      idxR    <= idxNextS;
      rfAddrR <= addrNextS;
      busyR   <= (nextStateS != ST_IDLE);
      doneR   <= (nextStateS == ST_DONE);
    end
  end

  rf_dump_outreg #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) uOutReg (
    .clk      (clk),
    .reset    (reset),
    .load     (loadS),
    .clear    (clearS),
    .dIn      (loadDataS),
    .tagIn    (loadTagS),
    .outData  (outData),
    .outTag   (outTag),
    .outValid (outValid)
  );

  assign rfAddr = rfAddrR;
  assign busy   = busyR;
  assign done   = doneR;

  // The package flags tag only matches the default register count.
  localparam logic [ADDR_W_DEF:0] TAG_DEF_CHK = FLAGS_TAG;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader. A queue of expected beats is built
// directly from the register contents (and flags word when RF_DUMP_FLAGS_EN
// is defined) and compared against every accepted beat.
module tb_rf_dump_reader;

  localparam int NREGS = 16;
`ifdef RF_DUMP_FLAGS_EN
  localparam int NBEATS    = NREGS + 1;
  localparam int DONE_CYC  = 2 * NREGS + 4;
`else
  localparam int NBEATS    = NREGS;
  localparam int DONE_CYC  = 2 * NREGS + 2;
`endif

  typedef struct {
    logic [4:0]  tag;
    logic [15:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        outReady = 1'b0;
  logic [3:0]  rfAddr;
  logic [15:0] rfData;
  logic [15:0] flags = 16'h0005;
  logic [15:0] outData;
  logic [4:0]  outTag;
  logic        outValid;
  logic        busy;
  logic        done;

  logic [15:0] rf [NREGS];
  beat_t       expQ[$];

  int checks = 0, passes = 0;
  int cyc = 0, doneCount = 0, doneCyc = 0, beats = 0, firstValidCyc = 0;
  bit stallPrev = 1'b0, abortSeen = 1'b0;
  logic [15:0] prevData;
  logic [4:0]  prevTag;

  always #5 clk = ~clk;

  assign rfData = rf[rfAddr];

  rf_dump_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .rfAddr   (rfAddr),
    .rfData   (rfData),
`ifdef RF_DUMP_FLAGS_EN
    .flags    (flags),
`endif
    .outData  (outData),
    .outTag   (outTag),
    .outValid (outValid),
    .outReady (outReady),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic buildExp();
    expQ.delete();
    for (int i = 0; i < NREGS; i++) expQ.push_back('{tag: 5'(i), data: rf[i]});
`ifdef RF_DUMP_FLAGS_EN
    expQ.push_back('{tag: 5'(NREGS), data: flags});
`endif
  endtask

  task automatic clearStats();
    doneCount = 0; doneCyc = 0; beats = 0; firstValidCyc = 0;
    stallPrev = 1'b0; abortSeen = 1'b0;
  endtask

  // One cycle: observe at the falling edge, then drive inputs for the next rise.
  task automatic tick(input bit newStart, input bit randReady, input int abortTag,
                      input int lateStartTag);
    bit rdy, ab, st;
    beat_t e;
    @(negedge clk);
    if (newStart) cyc = 1; else cyc++;
    rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    ab  = (abortTag >= 0) && outValid && (int'(outTag) == abortTag);
    st  = newStart || ((lateStartTag >= 0) && outValid && (int'(outTag) == lateStartTag));
    outReady = rdy; abort = ab; start = st;
    if (ab) abortSeen = 1'b1;
    if (stallPrev) begin
      chk("holdData", 32'(outData), 32'(prevData));
      chk("holdTag", 32'(outTag), 32'(prevTag));
    end
    stallPrev = outValid && !rdy && !ab;
    prevData = outData;
    prevTag  = outTag;
    if (outValid && firstValidCyc == 0) firstValidCyc = cyc;
    if (outValid && rdy && !ab) begin
      beats++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("beatTag", 32'(outTag), 32'(e.tag));
        chk("beatData", 32'(outData), 32'(e.data));
      end
    end
    if (done) begin
      doneCount++;
      doneCyc = cyc;
    end
  endtask

  task automatic runDump(input bit randReady, input int lateStartTag, input int budget);
    clearStats();
    buildExp();
    tick(1'b1, randReady, -1, -1);
    for (int k = 0; k < budget && doneCount == 0; k++) tick(1'b0, randReady, -1, lateStartTag);
    chk("doneSeen", 32'(doneCount), 32'd1);
    chk("beatCount", 32'(beats), 32'(NBEATS));
    chk("expEmpty", 32'(expQ.size()), 32'd0);
    tick(1'b0, 1'b1, -1, -1);
    chk("doneOneCycle", 32'(done), 32'd0);
    chk("busyAfter", 32'(busy), 32'd0);
    chk("doneCountAfter", 32'(doneCount), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rstAddr", 32'(rfAddr), 32'd0);
    chk("rstData", 32'(outData), 32'd0);
    chk("rstTag", 32'(outTag), 32'd0);
    chk("rstValid", 32'(outValid), 32'd0);
    chk("rstBusy", 32'(busy), 32'd0);
    chk("rstDone", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Full dump with ready held high
    for (int i = 0; i < NREGS; i++) rf[i] = 16'h1000 + 16'(i);
    runDump(1'b0, -1, 200);
    chk("doneCycle", 32'(doneCyc), 32'(DONE_CYC));
    chk("firstValidCycle", 32'(firstValidCyc), 32'd3);

    // Random backpressure, random register contents
    for (int i = 0; i < NREGS; i++) rf[i] = 16'($urandom);
    runDump(1'b1, -1, 2000);
    for (int i = 0; i < NREGS; i++) rf[i] = 16'h1000 + 16'(i);
    runDump(1'b1, -1, 2000);

    // Abort in SEND of tag 5 together with ready
    clearStats();
    buildExp();
    tick(1'b1, 1'b0, 5, -1);
    for (int k = 0; k < 200 && !abortSeen; k++) tick(1'b0, 1'b0, 5, -1);
    chk("abortReached", 32'(abortSeen), 32'd1);
    expQ.delete();
    tick(1'b0, 1'b0, -1, -1);
    chk("abortValid", 32'(outValid), 32'd0);
    chk("abortBusy", 32'(busy), 32'd0);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, -1, -1);
    chk("abortNoDone", 32'(doneCount), 32'd0);
    chk("abortBeats", 32'(beats), 32'd5);
    runDump(1'b0, -1, 200);
    chk("restartDoneCycle", 32'(doneCyc), 32'(DONE_CYC));

    // Start pulsed while busy at tag 7 is ignored
    runDump(1'b0, 7, 200);
    chk("lateStartDoneCycle", 32'(doneCyc), 32'(DONE_CYC));

    // Asynchronous reset mid-beat
    clearStats();
    buildExp();
    tick(1'b1, 1'b0, -1, -1);
    for (int k = 0; k < 200 && beats < 3; k++) tick(1'b0, 1'b0, -1, -1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arstAddr", 32'(rfAddr), 32'd0);
    chk("arstData", 32'(outData), 32'd0);
    chk("arstTag", 32'(outTag), 32'd0);
    chk("arstValid", 32'(outValid), 32'd0);
    chk("arstBusy", 32'(busy), 32'd0);
    chk("arstDone", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clearStats();
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, -1, -1);
    chk("postRstBusy", 32'(busy), 32'd0);
    chk("postRstValid", 32'(outValid), 32'd0);
    chk("postRstDone", 32'(doneCount), 32'd0);
    chk("postRstBeats", 32'(beats), 32'd0);
    runDump(1'b0, -1, 200);
    chk("postRstDoneCycle", 32'(doneCyc), 32'(DONE_CYC));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rf_dump_reader.md
# rf_dump_reader

Sequential read-out engine for the 16-entry register file and the PSR. On a `start` pulse it walks register addresses 0 to NREGS-1 through one register-file read port. It captures each value and streams it out one word per beat over a valid/ready handshake. Optionally it appends the PSR flags word. It sits beside the datapath as the read-side counterpart to the writeback path, and is used for debug dumps and for bench checking of register contents.

## Interface
- WIDTH, 16, data word width (register and flags width)
- NREGS, 16, number of registers walked
- ADDR_W, 4, register address width, with NREGS <= 2**ADDR_W
- clk  input  1  clock; all state is updated on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a dump; ignored unless the block is in IDLE
- abort  input  1  synchronous cancel of a dump in progress
- rfAddr  output  ADDR_W  read address driven to the register-file read port
- rfData  input  WIDTH  combinational read data returned for `rfAddr`
- flags  input  WIDTH  PSR flags word; present only with `RF_DUMP_FLAGS_EN`
- outData  output  WIDTH  captured word for the current beat
- outTag  output  ADDR_W+1  register index of the beat; value NREGS marks the flags beat
- outValid  output  1  `outData` and `outTag` are valid
- outReady  input  1  downstream accepts the beat
- busy  output  1  a dump is in progress (any state other than IDLE)
- done  output  1  one-cycle pulse after the final beat is accepted

## Operation
- States:
  - IDLE: `busy`=0, `outValid`=0. `start`=1 → FETCH with idx=0.
  - FETCH: `rfAddr`=idx. At the clock edge, `outData`←rfData and `outTag`←idx, then → SEND.
  - SEND: `outValid`=1; `outData` and `outTag` are held stable until the handshake.
    - On `outValid`&`outReady`: if idx < NREGS-1, then idx++ and → FETCH.
    - Otherwise → FLAGS if the macro is defined, else → DONE.
  - FLAGS: `outData`←flags and `outTag`←NREGS at the clock edge, then → SEND_F.
  - SEND_F: same handshake as SEND; on the handshake → DONE.
  - DONE: `done`=1 for exactly one cycle, then → IDLE.
- `abort`=1 in any non-IDLE state → IDLE at the next edge.
  - `outValid` drops, `done` is not pulsed, and idx clears.
  - `abort` takes priority over a handshake in the same cycle; that beat counts as not delivered.
- `start` and `abort` asserted together in IDLE: `start` wins.
- `start` while busy: ignored, with no restart and no queueing.
- idx compares against NREGS-1 and never wraps. Address NREGS is never driven on `rfAddr`.
- `rfAddr` holds its last value outside FETCH.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, idx=0.
  - `rfAddr`=0, `outData`=0, `outTag`=0.
  - `outValid`=0, `busy`=0, `done`=0.
- Reset asserted mid-dump forces these values immediately, with no `done` pulse.
- `start` seen at edge N:
  - FETCH in cycle N+1.
  - `outValid`=1 in cycle N+2 with tag 0.
- Each beat is 2 cycles minimum, with `outReady` held high.
- Full dump:
  - 2·NREGS + 2 cycles from `start` to `done`, i.e. 34 with defaults and no macro.
  - Add 2 cycles with the flags beat.
- `rfData` must be settled within the FETCH cycle; the register-file read is combinational.
- Outputs are registered. `busy` and `done` are decoded from the state register.

## Configuration
- `RF_DUMP_FLAGS_EN` defined: the `flags` port exists, and the FLAGS and SEND_F states append one beat with tag NREGS.
- `RF_DUMP_FLAGS_EN` undefined: the `flags` port is absent, FLAGS/SEND_F are absent, and the dump ends after tag NREGS-1.

## Structure
- The shared package holds:
  - the state enum localparams (IDLE, FETCH, SEND, FLAGS, SEND_F, DONE) and the state width;
  - the flags-beat tag constant;
  - the WIDTH and ADDR_W defaults.
- Sub-module `rf_dump_outreg` is the output holding register for `outData`, `outTag` and `outValid`.
  - It has load and clear inputs.
  - It guarantees the hold-while-stalled rule.
- The FSM and the index counter stay in the top level.

## Test plan
- Preload registers r[i]=16'h1000+i, pulse `start`, hold `outReady`=1.
  - Required: 16 beats with tags 0..15 and data 16'h1000..16'h100F.
  - `done` pulses exactly at cycle 34; `busy` is low afterwards.
- Same preload, toggle `outReady` randomly.
  - Required: `outData` and `outTag` stay unchanged while `outValid`&!`outReady`.
  - No beat is lost or duplicated.
- Assert `abort` in SEND of tag 5 together with `outReady`=1.
  - Required: `outValid`=0 next cycle, no `done` pulse, `busy`=0.
  - A fresh `start` restarts at tag 0.
- Pulse `start` again at tag 7.
  - Required: it is ignored, and the sequence continues 8..15 with a single `done`.
- Drive `reset`=0 asynchronously mid-beat.
  - Required: all outputs are 0 immediately; after release the block is idle until `start`.
- With `RF_DUMP_FLAGS_EN` and flags=16'h0005.
  - Required: a 17th beat with tag 16 and data 16'h0005; `done` at cycle 36.
